// File: rtl/axi4s_pkg.sv
// Shared helpers for the AXI-Stream packet tracker: width derivation and
// accessors for the tuser layout {error, trailing byte count}.
package axi4s_pkg;

  function automatic int bpw_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int wcw_of(input int max_bytes, input int data_width);
    return $clog2(max_bytes / (data_width / 8)) + 1;
  endfunction

  function automatic logic [31:0] make_user(input logic err, input int bytes,
                                            input int user_width);
    logic [31:0] u;
    u = 32'(bytes) & ((32'd1 << (user_width - 1)) - 32'd1);
    u[user_width-1] = err;
    return u;
  endfunction

  function automatic logic user_error(input logic [31:0] user, input int user_width);
    return user[user_width-1];
  endfunction

  // A zero byte-count field means a completely full beat.
  function automatic int user_bytes(input logic [31:0] user, input int user_width,
                                    input int bpw);
    int field;
    field = int'(user & ((32'd1 << (user_width - 1)) - 32'd1));
    return (field == 0) ? bpw : field;
  endfunction

endpackage

// File: rtl/axi_stream_packet_if_if.sv
// AXI-Stream beat bundle; master drives the beat, slave drives tready.
interface axi4s_if #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4
) ();
  localparam int BPW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic [BPW-1:0]        tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axi4s_word_counter.sv
// Beat position within the current packet plus per-query "byte is in this
// beat" compares against that position.
module axi4s_word_counter #(
  parameter int WCW = 14,
  parameter int BPW = 8,
  parameter int NQ  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                advance,
  input  logic                last,
  input  logic [NQ-1:0][15:0] query,
  output logic [WCW-1:0]      word_count,
  output logic [NQ-1:0]       reached
);
  localparam int SH = $clog2(BPW);

  // Oversize packets pin at the maximum count rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (advance) begin
      if (last)
        word_count <= '0;
      else if (word_count != {WCW{1'b1}})
        word_count <= word_count + 1'b1;
    end
  end

  always_comb begin
    reached = '0;
    for (int i = 0; i < NQ; i++)
      reached[i] = (32'(query[i] >> SH) == 32'(word_count));
  end
endmodule

// File: rtl/axi_stream_packet_if.sv
// Zero-latency AXI-Stream pass-through that reports where the current beat
// sits inside its packet, how many bytes it carries and its error flag.
module axi_stream_packet_if
  import axi4s_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int USER_WIDTH       = 4,
  parameter int TKEEP            = 1,
  parameter int MAX_PACKET_BYTES = 65536,
  localparam int BPW = bpw_of(DATA_WIDTH),
  localparam int WCW = wcw_of(MAX_PACKET_BYTES, DATA_WIDTH),
  localparam int BCW = $clog2(BPW + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  axi4s_if.slave         s,
  axi4s_if.master        m,
  input  logic [15:0]    query_a,
  input  logic [15:0]    query_b,
  output logic           reached_a,
  output logic           reached_b,
  output logic [WCW-1:0] word_count,
  output logic [BCW-1:0] word_bytes,
  output logic           error_bit
);
  logic       handshake;
  logic [1:0] reached;

  assign m.tdata  = s.tdata;
  assign m.tuser  = s.tuser;
  assign m.tlast  = s.tlast;
  assign m.tvalid = s.tvalid;
  assign s.tready = m.tready;

  generate
    if (TKEEP != 0) begin : g_keep
      assign m.tkeep = s.tkeep;
    end else begin : g_no_keep
      assign m.tkeep = '1;
    end
  endgenerate

  assign handshake = s.tvalid && m.tready;
  assign error_bit = user_error(32'(s.tuser), USER_WIDTH);

  // On the last beat tkeep is the authoritative byte count when present.
  always_comb begin
    word_bytes = BCW'(user_bytes(32'(s.tuser), USER_WIDTH, BPW));
    if (TKEEP != 0 && s.tlast) begin
      word_bytes = '0;
      for (int i = 0; i < BPW; i++)
        word_bytes = word_bytes + BCW'(s.tkeep[i]);
    end
  end

  axi4s_word_counter #(
    .WCW (WCW),
    .BPW (BPW),
    .NQ  (2)
  ) u_word_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (handshake),
    .last       (s.tlast),
    .query      ({query_b, query_a}),
    .word_count (word_count),
    .reached    (reached)
  );

  assign reached_a = reached[0];
  assign reached_b = reached[1];
endmodule

// File: tb/tb_axi_stream_packet_if.sv
// Drives a 64-bit (tkeep, small max packet) and a 32-bit (no tkeep) instance
// with the same handshake pattern and checks both against a packet-level model.
module tb_axi_stream_packet_if;
  localparam int MAX_A = 31;     // 128 bytes / 8 -> 16 words -> 5-bit count
  localparam int MAX_B = 32767;  // 65536 bytes / 4 -> 16384 words -> 15-bit count

  logic clk;
  logic rst_n;
  logic [15:0] qa, qb;

  axi4s_if #(.DATA_WIDTH(64), .USER_WIDTH(4)) sa ();
  axi4s_if #(.DATA_WIDTH(64), .USER_WIDTH(4)) ma ();
  axi4s_if #(.DATA_WIDTH(32), .USER_WIDTH(3)) sb ();
  axi4s_if #(.DATA_WIDTH(32), .USER_WIDTH(3)) mb ();

  logic        ra_a, rb_a, err_a, ra_b, rb_b, err_b;
  logic [4:0]  wc_a;
  logic [3:0]  wb_a;
  logic [14:0] wc_b;
  logic [2:0]  wb_b;

  axi_stream_packet_if #(.DATA_WIDTH(64), .USER_WIDTH(4), .TKEEP(1),
                         .MAX_PACKET_BYTES(128)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(sa), .m(ma), .query_a(qa), .query_b(qb),
    .reached_a(ra_a), .reached_b(rb_a), .word_count(wc_a),
    .word_bytes(wb_a), .error_bit(err_a));

  axi_stream_packet_if #(.DATA_WIDTH(32), .USER_WIDTH(3), .TKEEP(0),
                         .MAX_PACKET_BYTES(65536)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(sb), .m(mb), .query_a(qa), .query_b(qb),
    .reached_a(ra_b), .reached_b(rb_b), .word_count(wc_b),
    .word_bytes(wb_b), .error_bit(err_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  logic [63:0] da;
  logic [3:0]  ua;
  logic [7:0]  ka;
  logic [31:0] db;
  logic [2:0]  ub;
  logic        vld, lst, rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_bytes(input int user, input int keep, input bit last,
                                   input int bpw, input int uw, input bit has_keep);
    int f;
    if (has_keep && last) begin
      f = 0;
      for (int i = 0; i < bpw; i++) f += (keep >> i) & 1;
      return f;
    end
    f = user % (1 << (uw - 1));
    return (f == 0) ? bpw : f;
  endfunction

  task automatic apply_stimulus();
    sa.tdata = da; sa.tuser = ua; sa.tkeep = ka; sa.tlast = lst; sa.tvalid = vld;
    sb.tdata = db; sb.tuser = ub; sb.tkeep = 4'hF; sb.tlast = lst; sb.tvalid = vld;
    ma.tready = rdy;
    mb.tready = rdy;
  endtask

  task automatic drive(input logic v, input logic l, input logic r, input bit fresh);
    if (fresh) begin
      da = {$urandom, $urandom};
      ua = 4'($urandom);
      ka = 8'($urandom);
      db = $urandom;
      ub = 3'($urandom);
    end
    vld = v; lst = l; rdy = r;
    apply_stimulus();
  endtask

  task automatic check_output();
    check("a_data",  ma.tdata,  da);
    check("a_user",  ma.tuser,  ua);
    check("a_keep",  ma.tkeep,  ka);
    check("a_last",  ma.tlast,  lst);
    check("a_valid", ma.tvalid, vld);
    check("a_ready", sa.tready, rdy);
    check("a_wc",    wc_a,      cnt_a);
    check("a_ra",    ra_a,      (qa / 8) == cnt_a);
    check("a_rb",    rb_a,      (qb / 8) == cnt_a);
    check("a_wb",    wb_a,      exp_bytes(ua, ka, lst, 8, 4, 1'b1));
    check("a_err",   err_a,     ua[3]);
    check("b_data",  mb.tdata,  db);
    check("b_keep",  mb.tkeep,  4'hF);
    check("b_wc",    wc_b,      cnt_b);
    check("b_ra",    ra_b,      (qa / 4) == cnt_b);
    check("b_rb",    rb_b,      (qb / 4) == cnt_b);
    check("b_wb",    wb_b,      exp_bytes(ub, 0, lst, 4, 3, 1'b0));
    check("b_err",   err_b,     ub[2]);
  endtask

  // Checks the current beat, then advances the model across one clock edge.
  task automatic finish_beat();
    check_output();
    @(posedge clk);
    if (vld && rdy) begin
      if (lst) begin
        cnt_a = 0;
        cnt_b = 0;
      end else begin
        cnt_a = (cnt_a < MAX_A) ? cnt_a + 1 : MAX_A;
        cnt_b = (cnt_b < MAX_B) ? cnt_b + 1 : MAX_B;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    qa = '0; qb = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_wc_a", wc_a, 0);
    check("rst_wc_b", wc_b, 0);
    check("rst_valid", ma.tvalid, 0);
    rst_n = 1'b1;
    #2;
    finish_beat();

    // 32-bit 3-beat packet, query_a=6 lands in beat 1
    qa = 16'd6; qb = 16'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 2, 1'b1, 1'b1);
      #2;
      check("r030_wc", wc_b, i);
      check("r030_ra", ra_b, i == 1);
      finish_beat();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    check("r030_wc_end", wc_b, 0);
    finish_beat();

    // 64-bit queries 0 and 6 share beat 0; 8 is beat 1
    qa = 16'd0; qb = 16'd6;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    check("r031_ra0", ra_a, 1);
    check("r031_rb0", rb_a, 1);
    qb = 16'd8;
    #1;
    check("r031_rb8_b0", rb_a, 0);
    finish_beat();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    check("r031_rb8_b1", rb_a, 1);
    check("r031_ra_b1", ra_a, 0);
    finish_beat();

    // Stall at word 1 for three cycles
    qa = 16'd9; qb = 16'd1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #2; finish_beat();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("r032_wc", wc_a, 1);
      check("r032_ra", ra_a, 1);
      finish_beat();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    check("r032_wc_go", wc_a, 1);
    finish_beat();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    check("r032_wc_last", wc_a, 2);
    finish_beat();

    // Error flag and byte counts from tuser / tkeep
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    ua = 4'b1011; ka = 8'h07;
    apply_stimulus();
    #2;
    check("r033_err", err_a, 1);
    check("r033_wb3", wb_a, 3);
    finish_beat();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    ua = 4'b0000; ka = 8'hFF;
    apply_stimulus();
    #2;
    check("r033_wb8", wb_a, 8);
    check("r033_err0", err_a, 0);
    finish_beat();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    ua = 4'b0000; ub = 3'b000;
    apply_stimulus();
    #2;
    check("r033_wb8_mid", wb_a, 8);
    check("r033_wb4_b", wb_b, 4);
    finish_beat();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #2; finish_beat();

    // Reset mid-packet at word 2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      #2; finish_beat();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    check("r034_wc2", wc_a, 2);
    rst_n = 1'b0;
    #1;
    check("r034_rst_a", wc_a, 0);
    check("r034_rst_b", wc_b, 0);
    check("r034_pass", ma.tdata, da);
    cnt_a = 0; cnt_b = 0;
    @(posedge clk);
    #1;
    check("r034_hold", wc_a, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 2, 1'b1, 1'b1);
      #2;
      check("r034_wc", wc_a, i);
      finish_beat();
    end

    // Back-to-back single-beat packets
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      #2;
      check("r035_wc", wc_a, 0);
      finish_beat();
    end

    // Oversize packet saturates the 64-bit instance
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, i == 39, 1'b1, 1'b1);
      #2;
      if (i == 39) begin
        check("sat_a", wc_a, MAX_A);
        check("sat_b", wc_b, 39);
      end
      finish_beat();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    #2; finish_beat();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        qa = 16'($urandom_range(0, 100));
        qb = 16'($urandom_range(0, 100));
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, !(vld && !rdy));
      #2; finish_beat();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
